// File: rtl/fir_out_decim.sv
// FIR output stage: warm-up discard, decimation, rounding shift, narrowing and output FIFO.
// Define FIR_OUT_SAT_EN to clamp the narrowed sample; otherwise the low OUT_W bits are kept.
module fir_out_decim #(
   parameter int DATA_W     = 32,
   parameter int OUT_W      = 16,
   parameter int SHIFT      = 8,
   parameter int DECIM      = 4,
   parameter int WARMUP     = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             in_y,
   input  logic                          in_valid,
   output logic [OUT_W-1:0]              out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam int DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [DATA_W:0] ROUND =
      (SHIFT > 0) ? ({{DATA_W{1'b0}}, 1'b1} << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

   logic [WARM_W-1:0]   warmCnt_q, warmCnt_d;
   logic [DEC_W-1:0]    decimCnt_q, decimCnt_d;
   logic                warmDone, keep;
   logic signed [DATA_W:0] sumW;
   logic [OUT_W-1:0]    narrow;
   logic                pipeValid_q;
   logic [OUT_W-1:0]    pipeData_q;
   logic [OUT_W-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wrPtr_q, rdPtr_q;
   logic [LVL_W-1:0]    level_q;
   logic                overflow_q;
   logic                full, pop, push;

   assign warmDone = (warmCnt_q == WARM_W'(WARMUP));

   // The decimation phase only starts advancing once warm-up has saturated.
   always_comb begin
      warmCnt_d  = warmCnt_q;
      decimCnt_d = decimCnt_q;
      keep       = 1'b0;
      if (in_valid) begin
         if (!warmDone) begin
            warmCnt_d = warmCnt_q + 1'b1;
         end else begin
            keep       = (decimCnt_q == '0);
            decimCnt_d = (decimCnt_q == DEC_W'(DECIM - 1)) ? '0 : decimCnt_q + 1'b1;
         end
      end
   end

   assign sumW = $signed({in_y[DATA_W-1], in_y}) + $signed(ROUND);

`ifdef FIR_OUT_SAT_EN
   localparam logic signed [DATA_W:0] SAT_MAX = {{(DATA_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [DATA_W:0] SAT_MIN = {{(DATA_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
   logic signed [DATA_W:0] scaledW;
   assign scaledW = sumW >>> SHIFT;

   always_comb begin
      narrow = scaledW[OUT_W-1:0];
      if (scaledW > SAT_MAX) begin
         narrow = SAT_MAX[OUT_W-1:0];
      end else if (scaledW < SAT_MIN) begin
         narrow = SAT_MIN[OUT_W-1:0];
      end
   end
`else
   assign narrow = OUT_W'(sumW >>> SHIFT);
`endif

   // A full FIFO still accepts the pipeline sample when the head leaves on the same edge.
   assign out_valid  = (level_q != '0);
   assign full       = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop        = out_valid && out_ready;
   assign push       = pipeValid_q && (!full || pop);
   assign out_data   = out_valid ? mem_q[rdPtr_q] : '0;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warmCnt_q   <= '0;
         decimCnt_q  <= '0;
         pipeValid_q <= 1'b0;
         pipeData_q  <= '0;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         warmCnt_q   <= warmCnt_d;
         decimCnt_q  <= decimCnt_d;
         pipeValid_q <= keep;
         if (keep) begin
            pipeData_q <= narrow;
         end
         if (push) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
         if (pipeValid_q && full && !pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= pipeData_q;
      end
   end

endmodule

// File: tb/tb_fir_out_decim.sv
// Self-checking bench for fir_out_decim with default parameters; honours FIR_OUT_SAT_EN.
// A queue-based reference model predicts FIFO contents, level and overflow every cycle.
module tb_fir_out_decim;

   localparam int DATA_W = 32, OUT_W = 16, SHIFT = 8, DECIM = 4, WARMUP = 10, DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DATA_W-1:0] in_y;
   logic              in_valid;
   logic [OUT_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic              overflow;
   logic [2:0]        fifo_level;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state: accepted-sample count, FIFO contents, pending kept sample, sticky flag.
   int              accCount;
   logic [OUT_W-1:0] modelQ[$];
   bit              pendValid;
   logic [OUT_W-1:0] pendData;
   bit              modelOvf;
   logic [OUT_W-1:0] popped[$];

   fir_out_decim dut (
      .clk(clk), .rst_n(rst_n), .in_y(in_y), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .overflow(overflow), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [OUT_W-1:0] scaleRef(input logic [DATA_W-1:0] y);
      longint v;
      v = longint'($signed(y));
      if (SHIFT > 0) v = v + (longint'(1) << (SHIFT - 1));
      v = v >>> SHIFT;
`ifdef FIR_OUT_SAT_EN
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
`endif
      return v[OUT_W-1:0];
   endfunction

   task automatic modelEdge(input bit v, input logic [DATA_W-1:0] y, input bit r);
      int sizeBefore;
      bit doPop;
      sizeBefore = modelQ.size();
      doPop = (sizeBefore > 0) && r;
      if (doPop) void'(modelQ.pop_front());
      if (pendValid) begin
         if (sizeBefore == DEPTH && !doPop) modelOvf = 1'b1;
         else modelQ.push_back(pendData);
      end
      pendValid = 1'b0;
      if (v) begin
         if (accCount >= WARMUP && ((accCount - WARMUP) % DECIM) == 0) begin
            pendValid = 1'b1;
            pendData  = scaleRef(y);
         end
         accCount++;
      end
   endtask

   task automatic checkModel();
      checkOutput("level", 32'(fifo_level), 32'(modelQ.size()));
      checkOutput("valid", 32'(out_valid), 32'(modelQ.size() > 0));
      checkOutput("overflow", 32'(overflow), 32'(modelOvf));
      if (modelQ.size() > 0) checkOutput("data", 32'(out_data), 32'(modelQ[0]));
   endtask

   // Drives one cycle of inputs, advances the model on the edge, then checks just after it.
   task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] y, input bit r);
      in_valid  = v;
      in_y      = y;
      out_ready = r;
      if (out_valid && r) popped.push_back(out_data);
      @(posedge clk);
      modelEdge(v, y, r);
      #1;
      checkModel();
   endtask

   task automatic feedKept(input logic [DATA_W-1:0] y, input bit r);
      applyStimulus(1'b1, y, r);
      for (int i = 0; i < DECIM - 1; i++) applyStimulus(1'b1, 32'h0, r);
   endtask

   task automatic doReset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_y      = '0;
      rst_n     = 1'b0;
      #1;
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_data", 32'(out_data), 32'd0);
      checkOutput("rst_ovf", 32'(overflow), 32'd0);
      checkOutput("rst_level", 32'(fifo_level), 32'd0);
      accCount  = 0;
      modelQ.delete();
      pendValid = 1'b0;
      modelOvf  = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic checkPopped(input string tag, input logic [OUT_W-1:0] exp[$]);
      checkOutput({tag, "_count"}, 32'(popped.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < popped.size(); i++)
         checkOutput(tag, 32'(popped[i]), 32'(exp[i]));
      popped.delete();
   endtask

   initial begin
      logic [OUT_W-1:0] exp[$];
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_y = '0;
      #2;
      doReset();

      // Warm-up and decimation: ramp k<<8, keep every fourth after ten discarded.
      popped.delete();
      for (int k = 0; k < 26; k++) applyStimulus(1'b1, DATA_W'(k) << 8, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);
      exp = '{16'd10, 16'd14, 16'd18, 16'd22};
      checkPopped("decim", exp);

      // Rounding and narrowing extremes.
      feedKept(32'h0001_2380, 1'b1);
      feedKept(32'hFFFF_FF80, 1'b1);
      feedKept(32'hFFFF_FE7F, 1'b1);
      feedKept(32'h7FFF_FFFF, 1'b1);
      feedKept(32'h8000_0000, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);
`ifdef FIR_OUT_SAT_EN
      exp = '{16'h0124, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h8000};
`else
      exp = '{16'h0124, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000};
`endif
      checkPopped("round", exp);

      // Overflow: six kept samples into a four-deep FIFO with no consumer.
      for (int n = 1; n <= 6; n++) feedKept(DATA_W'(n) << 8, 1'b0);
      checkOutput("ovf_level", 32'(fifo_level), 32'd4);
      checkOutput("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1);
      exp = '{16'd1, 16'd2, 16'd3, 16'd4};
      checkPopped("ovf_drain", exp);
      checkOutput("ovf_sticky", 32'(overflow), 32'd1);

      // Full FIFO with simultaneous push and pop.
      doReset();
      for (int i = 0; i < WARMUP; i++) applyStimulus(1'b1, 32'h1234, 1'b0);
      for (int n = 1; n <= 4; n++) feedKept(DATA_W'(n + 20) << 8, 1'b0);
      applyStimulus(1'b1, 32'h0000_1900, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("pp_level", 32'(fifo_level), 32'd4);
      checkOutput("pp_ovf", 32'(overflow), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("pp_hold", 32'(out_data), 32'd22);

      // Reset mid-stream with three entries queued.
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("mid_level", 32'(fifo_level), 32'd3);
      doReset();
      popped.delete();
      for (int i = 0; i < WARMUP; i++) applyStimulus(1'b1, DATA_W'(i + 1) << 8, 1'b1);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("warm_level", 32'(fifo_level), 32'd0);
      feedKept(32'h0000_0B00, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      exp = '{16'h000B};
      checkPopped("warm_first", exp);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic [DATA_W-1:0] y;
         case ($urandom_range(0, 3))
            0: y = $urandom;
            1: y = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: y = DATA_W'($signed(16'($urandom)) <<< ($urandom_range(0, 12)));
         endcase
         applyStimulus($urandom_range(0, 4) != 0, y, $urandom_range(0, 2) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
